block_dezigzag_dequant: RTL and testbench
=========================================

Name: block_dezigzag_dequant

Overview:
Decode-side counterpart of the per-block quantize/zigzag stage in the image compressor. It accepts one 8x8 block of quantized coefficients streamed in zigzag order, with optional early end-of-block. It multiplies each coefficient by a programmable per-position quantizer step, stores the result in raster position, then streams the 64 dequantized coefficients out in raster order to the inverse-DCT stage.

Parameters:
COEF_WIDTH, 16, signed quantized coefficient width on input.
QTAB_WIDTH, 8, unsigned quantizer step width.
OUT_WIDTH, COEF_WIDTH+QTAB_WIDTH (24), signed dequantized output width. Derived; must not be overridden.
BLOCK_SIZE, 8, block edge. Fixed at 8 because the zigzag table is 8x8-specific.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input coefficient valid
in_ready  out  1  block can accept a coefficient
in_coef  in  COEF_WIDTH  signed quantized coefficient, zigzag order
in_last  in  1  end-of-block marker on the current beat
qtab_we  in  1  quantizer table write enable
qtab_addr  in  6  table index, raster order (row*8+col)
qtab_data  in  QTAB_WIDTH  unsigned quantizer step
out_valid  out  1  output coefficient valid
out_ready  in  1  downstream accepts
out_coef  out  OUT_WIDTH  signed dequantized coefficient
out_row  out  3  raster row of out_coef
out_col  out  3  raster column of out_coef
out_last  out  1  high on position 63 (row 7, col 7)
block_done  out  1  one-cycle pulse after the final output handshake

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_coef=0, out_row=0, out_col=0, out_last=0, block_done=0. State is FILL. Zigzag index k=0, raster counter r=0, written-mask all 0. Every quantizer table entry is 1 (identity).
- States:
  - FILL: in_ready=1, out_valid=0.
  - DRAIN: in_ready=0, out_valid=1.
  - No idle state; FILL waiting for in_valid is the idle condition.
- Input handshake: a beat transfers when in_valid && in_ready.
  - On each transfer, compute p = ZZ[k], the standard JPEG 8x8 zigzag-to-raster map (ZZ[0..9] = 0,1,8,16,9,2,3,10,17,24; ZZ[63]=63).
  - Write buf[p] = in_coef * qtab[p], using a signed x zero-extended unsigned multiply. The product is exact in OUT_WIDTH bits, so there is no rounding or saturation.
  - Set mask[p]=1 and increment k.
- End of fill: FILL->DRAIN on the transfer where k==63 or in_last==1, whichever comes first.
  - An early in_last (k<63) is an end-of-block: all unwritten positions read as 0 via the mask. There is no zero-fill cycle.
  - in_last at k==63 is equivalent to no in_last.
- Output: in DRAIN, out_coef = mask[r] ? buf[r] : 0, with out_row=r[5:3], out_col=r[2:0], out_last=(r==63). These are combinational from registered r/buf/mask.
  - On out_valid && out_ready, r increments.
  - out_valid with out_ready=0 must hold all out_* stable.
- End of drain: on the handshake at r==63, go to DRAIN->FILL. k, r and mask clear and block_done pulses for exactly the next cycle; in_ready=1 in that same cycle.
- Latency: the first out_valid appears the cycle after the final input transfer. Throughput is one coefficient per cycle each way. A full block takes 128 cycles minimum; there is no overlap of fill and drain.
- Quantizer table:
  - Writes are accepted in any state and take effect the next cycle.
  - An input transfer in the same cycle as a write to the same address uses the old value.
  - Values already stored in buf are never rescaled.
  - qtab_data=0 is legal and yields 0.
- in_valid during DRAIN is ignored and nothing is consumed. out_ready outside DRAIN is ignored.
- rst mid-block: immediately returns to the reset values, the partial block is discarded, and the quantizer table reverts to all 1.

Test Plan:
- Identity table, input coefficient = zigzag index k (0..63), no in_last. Required outputs in raster order: out(r=1)=1, out(r=8)=2, out(r=2)=5, out(r=63)=63. out_last only at r=63, block_done one cycle after that handshake.
- Load qtab[0]=16 and qtab[1]=11, then send coefficients -3, 2, 0 ... Required: out(0,0)=-48 and out(0,1)=22. Send -32768 with qtab[0]=255: required -8355840 with no overflow.
- Early EOB: 5 beats of 7 with in_last on beat 4. Required: DRAIN the next cycle; raster positions 0,1,8,16,9 = 7; the other 59 outputs = 0; 64 outputs total.
- Backpressure: random out_ready at 30% duty. Required: outputs stable while stalled, no drops or duplicates, in_ready=0 for the whole DRAIN, and a second block accepted immediately after block_done.
- Table write during FILL to qtab[p] at the cycle coefficient p arrives. Required: the old step is used; the next block uses the new step.
- Assert rst after 20 input beats. Required: out_valid=0 and in_ready=1 immediately. A fresh 64-beat block then decodes with the identity table and shows no residue from the aborted block.

Source files
------------

// File: rtl/block_dezigzag_dequant.sv
// rtl/block_dezigzag_dequant.sv - 8x8 zigzag-to-raster reorder with per-position dequantization
//
// Accepts one 8x8 block of quantized coefficients in zigzag order, multiplies
// each by the quantizer step of its raster position and stores it. Then it
// streams all 64 dequantized coefficients out in raster order.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      input beat handshake
//   in_coef, in_last       signed coefficient (zigzag order), end-of-block marker
//   qtab_we/addr/data      quantizer step write port, raster-ordered index
//   out_valid/out_ready    output beat handshake
//   out_coef               signed dequantized coefficient
//   out_row, out_col       raster position of out_coef
//   out_last               high on position 63
//   block_done             one-cycle pulse after the final output handshake
module block_dezigzag_dequant #(
  parameter int COEF_WIDTH = 16,
  parameter int QTAB_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [COEF_WIDTH-1:0]         in_coef,
  input  logic                                 in_last,
  input  logic                                 qtab_we,
  input  logic [5:0]                           qtab_addr,
  input  logic [QTAB_WIDTH-1:0]                qtab_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [COEF_WIDTH+QTAB_WIDTH-1:0] out_coef,
  output logic [2:0]                           out_row,
  output logic [2:0]                           out_col,
  output logic                                 out_last,
  output logic                                 block_done
);

  localparam int OUT_WIDTH  = COEF_WIDTH + QTAB_WIDTH;
  localparam int BLOCK_SIZE = 8;
  localparam int NCOEF      = BLOCK_SIZE * BLOCK_SIZE;
  localparam logic [5:0] LAST_IDX = 6'(NCOEF - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                 state, state_next;
  logic [5:0]             k;
  logic [5:0]             r;
  logic [NCOEF-1:0]       mask;
  logic [QTAB_WIDTH-1:0]  qtab     [NCOEF];
  logic [OUT_WIDTH-1:0]   coef_buf [NCOEF];
  logic [5:0]             zz_pos;
  logic                   in_fire;
  logic                   out_fire;
  logic signed [OUT_WIDTH-1:0] coef_ext;
  logic signed [OUT_WIDTH-1:0] step_ext;
  logic signed [OUT_WIDTH-1:0] product;

  // Standard JPEG zigzag index -> raster index (row*8+col).
  function automatic logic [5:0] zigzag(input logic [5:0] idx);
    zigzag = 6'd0;
    case (idx)
      6'd0:  zigzag = 6'd0;  6'd1:  zigzag = 6'd1;  6'd2:  zigzag = 6'd8;  6'd3:  zigzag = 6'd16;
      6'd4:  zigzag = 6'd9;  6'd5:  zigzag = 6'd2;  6'd6:  zigzag = 6'd3;  6'd7:  zigzag = 6'd10;
      6'd8:  zigzag = 6'd17; 6'd9:  zigzag = 6'd24; 6'd10: zigzag = 6'd32; 6'd11: zigzag = 6'd25;
      6'd12: zigzag = 6'd18; 6'd13: zigzag = 6'd11; 6'd14: zigzag = 6'd4;  6'd15: zigzag = 6'd5;
      6'd16: zigzag = 6'd12; 6'd17: zigzag = 6'd19; 6'd18: zigzag = 6'd26; 6'd19: zigzag = 6'd33;
      6'd20: zigzag = 6'd40; 6'd21: zigzag = 6'd48; 6'd22: zigzag = 6'd41; 6'd23: zigzag = 6'd34;
      6'd24: zigzag = 6'd27; 6'd25: zigzag = 6'd20; 6'd26: zigzag = 6'd13; 6'd27: zigzag = 6'd6;
      6'd28: zigzag = 6'd7;  6'd29: zigzag = 6'd14; 6'd30: zigzag = 6'd21; 6'd31: zigzag = 6'd28;
      6'd32: zigzag = 6'd35; 6'd33: zigzag = 6'd42; 6'd34: zigzag = 6'd49; 6'd35: zigzag = 6'd56;
      6'd36: zigzag = 6'd57; 6'd37: zigzag = 6'd50; 6'd38: zigzag = 6'd43; 6'd39: zigzag = 6'd36;
      6'd40: zigzag = 6'd29; 6'd41: zigzag = 6'd22; 6'd42: zigzag = 6'd15; 6'd43: zigzag = 6'd23;
      6'd44: zigzag = 6'd30; 6'd45: zigzag = 6'd37; 6'd46: zigzag = 6'd44; 6'd47: zigzag = 6'd51;
      6'd48: zigzag = 6'd58; 6'd49: zigzag = 6'd59; 6'd50: zigzag = 6'd52; 6'd51: zigzag = 6'd45;
      6'd52: zigzag = 6'd38; 6'd53: zigzag = 6'd31; 6'd54: zigzag = 6'd39; 6'd55: zigzag = 6'd46;
      6'd56: zigzag = 6'd53; 6'd57: zigzag = 6'd60; 6'd58: zigzag = 6'd61; 6'd59: zigzag = 6'd54;
      6'd60: zigzag = 6'd47; 6'd61: zigzag = 6'd55; 6'd62: zigzag = 6'd62; 6'd63: zigzag = 6'd63;
    endcase
  endfunction

  assign zz_pos   = zigzag(k);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Signed coefficient times zero-extended step; the true product always fits
  // in OUT_WIDTH signed bits, so the truncated result is exact.
  assign coef_ext = {{QTAB_WIDTH{in_coef[COEF_WIDTH-1]}}, in_coef};
  assign step_ext = {{COEF_WIDTH{1'b0}}, qtab[zz_pos]};
  assign product  = coef_ext * step_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        // in_last at k==63 coincides with the natural end, so both are one case
        if (in_valid && (k == LAST_IDX || in_last)) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && r == LAST_IDX) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k          <= 6'd0;
      r          <= 6'd0;
      mask       <= '0;
      block_done <= 1'b0;
      for (int i = 0; i < NCOEF; i++) qtab[i] <= QTAB_WIDTH'(1);
    end else begin
      block_done <= 1'b0;
      // An input beat in the same cycle reads the pre-write step.
      if (qtab_we) qtab[qtab_addr] <= qtab_data;
      if (in_fire) begin
        mask[zz_pos] <= 1'b1;
        k            <= k + 6'd1;
      end
      if (out_fire) begin
        if (r == LAST_IDX) begin
          r          <= 6'd0;
          k          <= 6'd0;
          mask       <= '0;
          block_done <= 1'b1;
        end else begin
          r <= r + 6'd1;
        end
      end
    end
  end

  // Storage needs no reset: the mask hides anything not written this block.
  always_ff @(posedge clk) begin
    if (in_fire) coef_buf[zz_pos] <= product;
  end

  assign out_coef = (state == DRAIN && mask[r]) ? coef_buf[r] : '0;
  assign out_row  = r[5:3];
  assign out_col  = r[2:0];
  assign out_last = (state == DRAIN) && (r == LAST_IDX);

endmodule

// File: tb/tb_block_dezigzag_dequant.sv
// tb/tb_block_dezigzag_dequant.sv - directed self-checking bench for block_dezigzag_dequant
module tb_block_dezigzag_dequant;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_coef;
  logic               in_last;
  logic               qtab_we;
  logic [5:0]         qtab_addr;
  logic [7:0]         qtab_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] out_coef;
  logic [2:0]         out_row;
  logic [2:0]         out_col;
  logic               out_last;
  logic               block_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int zz[64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                 12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                 35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                 58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  int got[64];
  int n_out, stall_err, ready_err, order_err, last_err;
  bit done_now, done_after, ready_now;

  block_dezigzag_dequant dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_coef    (in_coef),
    .in_last    (in_last),
    .qtab_we    (qtab_we),
    .qtab_addr  (qtab_addr),
    .qtab_data  (qtab_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_coef   (out_coef),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .block_done (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus helpers are entered and left at a falling edge.
  task automatic beat(input int c, input bit last);
    in_valid = 1'b1;
    in_coef  = 16'(c);
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_ramp(input int base);
    for (int i = 0; i < 64; i++) beat(base + i, 1'b0);
  endtask

  task automatic write_q(input int a, input int d);
    qtab_we   = 1'b1;
    qtab_addr = 6'(a);
    qtab_data = 8'(d);
    @(negedge clk);
    qtab_we   = 1'b0;
  endtask

  // Collects one drained block into got[] (indexed by raster position) and
  // records protocol observations for the calling test to judge.
  task automatic drain(input int duty);
    int cyc, idx, h_coef;
    bit stalled;
    logic [2:0] h_row, h_col;
    logic h_last;
    n_out = 0; stall_err = 0; ready_err = 0; order_err = 0; last_err = 0;
    cyc = 0; stalled = 0; h_coef = 0; h_row = 0; h_col = 0; h_last = 0;
    for (int i = 0; i < 64; i++) got[i] = -999999;
    while (n_out < 64 && cyc < 3000) begin
      out_ready = ($urandom_range(99) < duty);
      if (out_valid) begin
        if (in_ready) ready_err++;
        if (stalled && (int'(out_coef) != h_coef || out_row != h_row ||
                        out_col != h_col || out_last != h_last)) stall_err++;
        if (out_ready) begin
          idx = int'({out_row, out_col});
          if (idx != n_out) order_err++;
          if (out_last != (idx == 63)) last_err++;
          got[idx] = int'(out_coef);
          n_out++;
          stalled = 0;
        end else begin
          stalled = 1;
          h_coef = int'(out_coef); h_row = out_row; h_col = out_col; h_last = out_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready  = 1'b0;
    done_now   = block_done;
    ready_now  = in_ready;
    @(negedge clk);
    done_after = block_done;
  endtask

  task automatic test_reset;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_coef !== 24'sd0 || out_row !== 3'd0 || out_col !== 3'd0 || out_last !== 1'b0)
      $display("FAIL reset_out_fields: got coef=%0d row=%0d col=%0d last=%b want 0 0 0 0", out_coef, out_row, out_col, out_last);
    else pass_cnt++;
    total_cnt++; if (block_done !== 1'b0) $display("FAIL reset_block_done: got %b want 0", block_done); else pass_cnt++;
  endtask

  task automatic test_identity;
    int bad;
    send_ramp(0);
    drain(100);
    total_cnt++; if (got[1] !== 1) $display("FAIL ident_r1: got %0d want 1", got[1]); else pass_cnt++;
    total_cnt++; if (got[8] !== 2) $display("FAIL ident_r8: got %0d want 2", got[8]); else pass_cnt++;
    total_cnt++; if (got[2] !== 5) $display("FAIL ident_r2: got %0d want 5", got[2]); else pass_cnt++;
    total_cnt++; if (got[63] !== 63) $display("FAIL ident_r63: got %0d want 63", got[63]); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[zz[i]] != i) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL ident_all: got %0d wrong positions want 0", bad); else pass_cnt++;
    total_cnt++; if (n_out !== 64 || order_err !== 0) $display("FAIL ident_order: got n=%0d order_err=%0d want 64 0", n_out, order_err); else pass_cnt++;
    total_cnt++; if (last_err !== 0) $display("FAIL ident_last: got %0d misplaced want 0", last_err); else pass_cnt++;
    total_cnt++; if (done_now !== 1'b1 || done_after !== 1'b0)
      $display("FAIL ident_done_pulse: got %b,%b want 1,0", done_now, done_after); else pass_cnt++;
    total_cnt++; if (ready_now !== 1'b1) $display("FAIL ident_ready_at_done: got %b want 1", ready_now); else pass_cnt++;
  endtask

  task automatic test_scaling;
    write_q(0, 16);
    write_q(1, 11);
    beat(-3, 1'b0);
    beat(2, 1'b0);
    for (int i = 2; i < 64; i++) beat(0, 1'b0);
    drain(100);
    total_cnt++; if (got[0] !== -48) $display("FAIL scale_r0: got %0d want -48", got[0]); else pass_cnt++;
    total_cnt++; if (got[1] !== 22) $display("FAIL scale_r1: got %0d want 22", got[1]); else pass_cnt++;
    write_q(0, 255);
    beat(-32768, 1'b1);
    drain(100);
    total_cnt++; if (got[0] !== -8355840) $display("FAIL scale_max: got %0d want -8355840", got[0]); else pass_cnt++;
    total_cnt++; if (got[1] !== 0) $display("FAIL scale_masked: got %0d want 0", got[1]); else pass_cnt++;
  endtask

  task automatic test_early_eob;
    int bad;
    write_q(0, 1);
    write_q(1, 1);
    for (int i = 0; i < 5; i++) beat(7, i == 4);
    total_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL eob_drain_next: got valid=%b ready=%b want 1 0", out_valid, in_ready); else pass_cnt++;
    drain(100);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 0 || i == 1 || i == 8 || i == 16 || i == 9) begin
        if (got[i] != 7) bad++;
      end else if (got[i] != 0) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL eob_values: got %0d wrong positions want 0", bad); else pass_cnt++;
    total_cnt++; if (n_out !== 64) $display("FAIL eob_count: got %0d want 64", n_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int bad;
    send_ramp(100);
    drain(30);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[zz[i]] != i + 100) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL bp_values: got %0d wrong positions want 0", bad); else pass_cnt++;
    total_cnt++; if (n_out !== 64 || order_err !== 0) $display("FAIL bp_order: got n=%0d order_err=%0d want 64 0", n_out, order_err); else pass_cnt++;
    total_cnt++; if (stall_err !== 0) $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_err); else pass_cnt++;
    total_cnt++; if (ready_err !== 0) $display("FAIL bp_in_ready: got %0d drain cycles with in_ready want 0", ready_err); else pass_cnt++;
    total_cnt++; if (done_now !== 1'b1 || ready_now !== 1'b1)
      $display("FAIL bp_done: got done=%b ready=%b want 1 1", done_now, ready_now); else pass_cnt++;
    send_ramp(0);
    drain(100);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[zz[i]] != i) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL bp_second_block: got %0d wrong positions want 0", bad); else pass_cnt++;
  endtask

  task automatic test_qtab_collision;
    // zigzag index 2 lands on raster 8; rewrite qtab[8] in that very cycle
    for (int i = 0; i < 64; i++) begin
      if (i == 2) begin
        qtab_we = 1'b1; qtab_addr = 6'd8; qtab_data = 8'd9;
      end
      beat(5, 1'b0);
      qtab_we = 1'b0;
    end
    drain(100);
    total_cnt++; if (got[8] !== 5) $display("FAIL coll_old_step: got %0d want 5", got[8]); else pass_cnt++;
    total_cnt++; if (got[0] !== 5) $display("FAIL coll_other: got %0d want 5", got[0]); else pass_cnt++;
    for (int i = 0; i < 64; i++) beat(5, 1'b0);
    drain(100);
    total_cnt++; if (got[8] !== 45) $display("FAIL coll_new_step: got %0d want 45", got[8]); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int bad;
    for (int i = 0; i < 20; i++) beat(77, 1'b0);
    rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_immediate: got valid=%b ready=%b want 0 1", out_valid, in_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    send_ramp(0);
    drain(100);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[zz[i]] != i) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL rst_mid_fresh: got %0d wrong positions want 0", bad); else pass_cnt++;
    total_cnt++; if (got[8] !== 2) $display("FAIL rst_mid_qtab: got %0d want 2", got[8]); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_coef = '0; in_last = 1'b0;
    qtab_we = 1'b0; qtab_addr = '0; qtab_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_identity;
    test_scaling;
    test_early_eob;
    test_back_to_back;
    test_qtab_collision;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
